pht_counter_table: RTL and testbench
====================================

Name: pht_counter_table

Overview:
- Parametrised pattern-history table for the branch predictor: an array of saturating counters with one lookup port and one update port.
- Each update is a pipelined read-modify-write that increments or decrements a counter with saturation, with forwarding across in-flight updates.
- A sweep FSM initialises every entry after reset or on a clear request.
- Sits between the fetch-stage predictor logic (lookups) and the branch-resolve stage (updates).

Parameters:
- ADDR_WIDTH, 4, table index width; RAM_DEPTH = 1 << ADDR_WIDTH.
- CTR_WIDTH, 2, counter width in bits (>= 1).
- INIT_VALUE, (1 << (CTR_WIDTH-1)) - 1, value written to every entry by the sweep (weakly not-taken).

Ports:
- clk0  in  1  clock.
- rst0  in  1  synchronous active-high reset.
- clear  in  1  request a full re-initialisation sweep.
- ready  out  1  table accepts lookups and updates.
- lk_valid  in  1  lookup request.
- lk_index  in  ADDR_WIDTH  lookup index.
- lk_rvalid  out  1  lookup result valid.
- lk_ctr  out  CTR_WIDTH  counter value.
- lk_taken  out  1  MSB of lk_ctr.
- up_valid  in  1  update request.
- up_index  in  ADDR_WIDTH  update index.
- up_taken  in  1  resolved direction: 1 = increment, 0 = decrement.

Behaviour:
- Interface: one clock (clk0); reset is synchronous and active-high (rst0). All state changes on the rising edge of clk0.
- FSM states: INIT and RUN.
  - rst0 = 1 -> INIT, sweep pointer = 0, all pipeline valids cleared. rst0 wins over every other input.
  - INIT: writes INIT_VALUE to mem[ptr] each cycle and increments ptr. After writing RAM_DEPTH-1, goes to RUN. The sweep takes exactly RAM_DEPTH cycles.
  - RUN: clear = 1 -> INIT with ptr = 0. In-flight updates are discarded and the pending lookup result is dropped (lk_rvalid = 0 next cycle).
  - clear is ignored in INIT; the sweep is not restarted.
- ready = 1 only in RUN. lk_valid and up_valid are ignored while ready = 0.
- Reset values: ready = 0, lk_rvalid = 0, lk_ctr = 0, lk_taken = 0.
- Lookup, 1-cycle latency:
  - lk_valid sampled at edge E registers the index.
  - lk_rvalid = 1 during the following cycle.
  - lk_ctr = mem[idx], or the stage-2 next value when stage 2 is valid with a matching index (forwarding).
  - lk_ctr holds its last value when lk_rvalid = 0.
- Update pipeline:
  - S1: sampled at edge E1.
  - Read: during the next cycle, mem[idx] (or the forwarded value) is registered at E2.
  - S2: during the cycle after E2, next = sat(ctr ± 1); written at E3.
  - Saturation: increment at 2^CTR_WIDTH-1 holds; decrement at 0 holds. No wrap.
- Forwarding: when S1 reads an index equal to a valid S2 index, it uses S2's next value instead of mem. This covers back-to-back updates to the same index.
- One update per cycle accepted; no backpressure.
- Lookup and update to the same index in the same cycle: the lookup sees the pre-update value. That update's write commits two edges later.
- Updates and lookups use separate paths; no port conflict stalls.

Test Plan:
- Reset for 1 cycle, defaults -> ready = 0 for exactly 16 cycles, then 1. Lookups of indices 0..15 all return lk_ctr = 1, lk_taken = 0.
- Up_taken = 1 to index 3 on three consecutive cycles -> lookup of index 3 afterwards returns 3 (1→2→3→3 saturated; forwarding exercised). Lookup issued the cycle after the third update is sampled returns 3.
- Up_taken = 0 to index 5 on two consecutive cycles, then once more two cycles later -> lk_ctr[5] = 0, saturated low, no wrap to 3.
- Alternating up_taken 1,0,1 to index 7, back-to-back -> final lk_ctr = 2. Each intermediate lookup matches the forwarded value.
- Set index 9 to 3, assert clear for 1 cycle mid-update -> ready low for 16 cycles, in-flight write discarded, lk_ctr[9] = 1 afterwards.
- Assert rst0 at sweep pointer 8 -> sweep restarts from 0 and ready rises exactly 16 cycles after rst0 deasserts. lk_valid/up_valid driven during INIT produce no lk_rvalid and no table change.

Source files
------------

// File: rtl/pht_counter_table.sv
// Pattern-history table of saturating counters: one lookup port, one pipelined
// read-modify-write update port with forwarding, and an init sweep after reset/clear.
module pht_counter_table #(
  parameter int ADDR_WIDTH = 4,
  parameter int CTR_WIDTH  = 2,
  parameter int INIT_VALUE = (1 << (CTR_WIDTH - 1)) - 1
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  clear,
  output logic                  ready,
  input  logic                  lk_valid,
  input  logic [ADDR_WIDTH-1:0] lk_index,
  output logic                  lk_rvalid,
  output logic [CTR_WIDTH-1:0]  lk_ctr,
  output logic                  lk_taken,
  input  logic                  up_valid,
  input  logic [ADDR_WIDTH-1:0] up_index,
  input  logic                  up_taken
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [CTR_WIDTH-1:0] INIT_CTR = CTR_WIDTH'(INIT_VALUE);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q;
  logic [CTR_WIDTH-1:0]    mem [RAM_DEPTH];

  logic                    accept_lk, accept_up;
  logic                    s1_valid, s1_taken;
  logic [ADDR_WIDTH-1:0]   s1_index;
  logic [CTR_WIDTH-1:0]    s1_rd;
  logic                    s2_valid, s2_taken;
  logic [ADDR_WIDTH-1:0]   s2_index;
  logic [CTR_WIDTH-1:0]    s2_ctr, s2_next;
  logic [ADDR_WIDTH-1:0]   lk_idx_q;
  logic [CTR_WIDTH-1:0]    lk_live, lk_hold;

  // ---------------- sweep FSM ----------------
  always_ff @(posedge clk0) begin
    if (rst0) state_q <= ST_INIT;
    else      state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (ptr_q == '1) state_d = ST_RUN;
      ST_RUN:  if (clear)       state_d = ST_INIT;
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk0) begin
    if (rst0)                   ptr_q <= '0;
    else if (state_q == ST_INIT) ptr_q <= ptr_q + ADDR_WIDTH'(1);
    else if (clear)             ptr_q <= '0;
  end

  assign ready     = (state_q == ST_RUN);
  assign accept_lk = lk_valid && ready && !clear;
  assign accept_up = up_valid && ready && !clear;

  // ---------------- update datapath ----------------
  assign s1_rd   = (s2_valid && s2_index == s1_index) ? s2_next : mem[s1_index];
  assign lk_live = (s2_valid && s2_index == lk_idx_q) ? s2_next : mem[lk_idx_q];

  always_comb begin
    s2_next = s2_ctr;
    if (s2_taken) begin
      if (s2_ctr != CTR_MAX) s2_next = s2_ctr + CTR_WIDTH'(1);
    end else begin
      if (s2_ctr != '0)      s2_next = s2_ctr - CTR_WIDTH'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      s1_valid  <= 1'b0;
      s1_taken  <= 1'b0;
      s1_index  <= '0;
      s2_valid  <= 1'b0;
      s2_taken  <= 1'b0;
      s2_index  <= '0;
      s2_ctr    <= '0;
      lk_rvalid <= 1'b0;
      lk_idx_q  <= '0;
      lk_hold   <= '0;
    end else begin
      s1_valid  <= accept_up;
      s1_taken  <= up_taken;
      s1_index  <= up_index;
      s2_valid  <= s1_valid && !clear;
      s2_taken  <= s1_taken;
      s2_index  <= s1_index;
      s2_ctr    <= s1_rd;
      lk_rvalid <= accept_lk;
      if (accept_lk) lk_idx_q <= lk_index;
      if (lk_rvalid) lk_hold  <= lk_live;
    end
  end

  // NOTE: the counter array has no reset; the sweep FSM initialises it instead.
  always_ff @(posedge clk0) begin
    if (!rst0) begin
      if (state_q == ST_INIT)
        mem[ptr_q] <= INIT_CTR;
      else if (s2_valid && !clear)
        mem[s2_index] <= s2_next;
    end
  end

  // Result is live while valid, otherwise the last delivered value is held.
  assign lk_ctr   = lk_rvalid ? lk_live : lk_hold;
  assign lk_taken = lk_ctr[CTR_WIDTH-1];

endmodule

// File: tb/tb_pht_counter_table.sv
// Directed self-checking bench for pht_counter_table (default parameters).
module tb_pht_counter_table;

  logic       clk0 = 1'b0;
  logic       rst0, clear, ready;
  logic       lk_valid, lk_rvalid, lk_taken;
  logic [3:0] lk_index;
  logic [1:0] lk_ctr;
  logic       up_valid, up_taken;
  logic [3:0] up_index;

  int errors = 0;
  int checks = 0;

  pht_counter_table dut (
    .clk0(clk0), .rst0(rst0), .clear(clear), .ready(ready),
    .lk_valid(lk_valid), .lk_index(lk_index), .lk_rvalid(lk_rvalid),
    .lk_ctr(lk_ctr), .lk_taken(lk_taken),
    .up_valid(up_valid), .up_index(up_index), .up_taken(up_taken)
  );

  always #5 clk0 = ~clk0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic lookup(input string tag, input logic [3:0] idx, input logic [1:0] exp);
    lk_valid = 1'b1;
    lk_index = idx;
    tick();
    lk_valid = 1'b0;
    check({tag, "_rvalid"}, lk_rvalid, 1);
    check(tag, lk_ctr, exp);
    check({tag, "_taken"}, lk_taken, exp[1]);
  endtask

  // Counts cycles until ready; optionally pulses clear at cycle clear_at (must be ignored).
  task automatic wait_ready(input string tag, input int clear_at);
    int  n    = 0;
    bit  seen = 1'b0;
    while (!ready && n < 64) begin
      clear = (n == clear_at);
      tick();
      clear = 1'b0;
      if (lk_rvalid) seen = 1'b1;
      n++;
    end
    lk_valid = 1'b0;
    up_valid = 1'b0;
    check({tag, "_cycles"}, n, 16);
    check({tag, "_no_rvalid"}, seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst0 = 1'b1; clear = 1'b0;
    lk_valid = 1'b0; lk_index = '0;
    up_valid = 1'b0; up_index = '0; up_taken = 1'b0;
    tick(); tick();
    check("rst_ready", ready, 0);
    check("rst_rvalid", lk_rvalid, 0);
    check("rst_ctr", lk_ctr, 0);
    check("rst_taken", lk_taken, 0);
    rst0 = 1'b0;
    wait_ready("init_sweep", -1);

    for (int i = 0; i < 16; i++) lookup($sformatf("init_lk%0d", i), 4'(i), 2'd1);

    // Three increments to index 3 back to back; lookup right after the third.
    up_valid = 1'b1; up_index = 4'd3; up_taken = 1'b1;
    repeat (3) tick();
    up_valid = 1'b0;
    lookup("inc3_fwd", 4'd3, 2'd3);
    repeat (3) tick();
    lookup("inc3_final", 4'd3, 2'd3);

    // Decrement index 5 twice, then once more two cycles later: saturates at 0.
    up_valid = 1'b1; up_index = 4'd5; up_taken = 1'b0;
    tick(); tick();
    up_valid = 1'b0;
    tick();
    up_valid = 1'b1;
    tick();
    up_valid = 1'b0;
    repeat (3) tick();
    lookup("dec5_sat", 4'd5, 2'd0);

    // Alternating updates to 7 with a lookup every cycle: 1 (same-cycle, pre-update), 2, 1, 2.
    begin
      logic [1:0] exp7 [4] = '{2'd1, 2'd2, 2'd1, 2'd2};
      logic       dir7 [3] = '{1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
        up_valid = (i < 3);
        up_index = 4'd7;
        up_taken = (i < 3) ? dir7[i] : 1'b0;
        lk_valid = 1'b1;
        lk_index = 4'd7;
        tick();
        check($sformatf("alt7_rvalid%0d", i), lk_rvalid, 1);
        check($sformatf("alt7_lk%0d", i), lk_ctr, exp7[i]);
      end
      up_valid = 1'b0;
      lk_valid = 1'b0;
    end
    repeat (3) tick();
    lookup("alt7_final", 4'd7, 2'd2);

    // Index 9 up to 3, then clear while a decrement is in flight.
    up_valid = 1'b1; up_index = 4'd9; up_taken = 1'b1;
    tick(); tick();
    up_valid = 1'b0;
    repeat (3) tick();
    lookup("set9", 4'd9, 2'd3);
    up_valid = 1'b1; up_taken = 1'b0;
    tick();
    up_valid = 1'b0;
    clear = 1'b1; lk_valid = 1'b1; lk_index = 4'd9;
    tick();
    clear = 1'b0; lk_valid = 1'b0;
    check("clear_ready", ready, 0);
    check("clear_rvalid_drop", lk_rvalid, 0);
    check("clear_ctr_hold", lk_ctr, 3);
    wait_ready("clear_sweep", 5);
    lookup("clear9", 4'd9, 2'd1);
    lookup("clear3", 4'd3, 2'd1);

    // Reset with the sweep pointer at 8; traffic during INIT must be ignored.
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    repeat (8) tick();
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    lk_valid = 1'b1; lk_index = 4'd0;
    up_valid = 1'b1; up_index = 4'd0; up_taken = 1'b1;
    wait_ready("rst8_sweep", -1);
    check("rst8_rvalid_after", lk_rvalid, 0);
    tick();
    lookup("rst8_lk0", 4'd0, 2'd1);
    lookup("rst8_lk15", 4'd15, 2'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
